dmem_ctrl: RTL and testbench

Data-memory controller that sits directly downstream of the execute/memory stage. It consumes that stage's load/store request (address, data, byte_size, read/write enables) and drives a word-wide synchronous SRAM with byte enables. It returns right-aligned, zero-extended load data plus one-cycle read/write ready pulses. Adds configurable wait states to model slower memory, and flags misaligned or illegal requests.

---
 rtl/dmem_ctrl_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/dmem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: datapath width,
// byte_size encodings and controller FSM states.
package dmem_ctrl_pkg;

  localparam int DMEM_XLEN        = 32;
  localparam int DMEM_MAX_BIT_POS = DMEM_XLEN - 1;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_BYTE = 2'd1,
    SIZE_HALF = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 4-lane word memory: store byte enables and
// replication, load extraction with zero extension, and misalignment flag.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]                addr_lo,
  input  logic [1:0]                byte_size,
  input  logic [DMEM_MAX_BIT_POS:0] wdata,
  input  logic [DMEM_MAX_BIT_POS:0] rdata,
  output logic [3:0]                be,
  output logic [DMEM_MAX_BIT_POS:0] wdata_rep,
  output logic [DMEM_MAX_BIT_POS:0] rdata_al,
  output logic                      misalign
);

  // Lane selection per access size; size 3 is always rejected.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_al  = rdata;
    misalign  = 1'b0;
    case (byte_size)
      SIZE_WORD: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_al  = {24'd0, rdata[{addr_lo, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_al  = {16'd0, rdata[{addr_lo[1], 4'b0000} +: 16]};
        misalign  = addr_lo[0];
      end
      default: begin
        be       = 4'b0000;
        rdata_al = 32'd0;
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns held load/store requests into single-cycle
// synchronous SRAM accesses with optional wait states and one-shot responses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [1:0]        byte_size,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  output logic [XLEN-1:0]   mem_data_in,
  output logic              mem_read_ready,
  output logic              mem_write_ready,
  output logic              mem_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [XLEN-1:0]   sram_wdata,
  input  logic [XLEN-1:0]   sram_rdata
);

  dmem_state_e       state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [1:0]        addr_lo_r, addr_lo_nxt_s;
  logic [1:0]        size_r, size_nxt_s;
  logic              rd_req_r, rd_req_nxt_s;
  logic              wr_req_r, wr_req_nxt_s;
  logic              err_pend_r, err_pend_nxt_s;

  logic [XLEN-1:0]   data_in_r, data_in_nxt_s;
  logic              rd_rdy_r, rd_rdy_nxt_s;
  logic              wr_rdy_r, wr_rdy_nxt_s;
  logic              err_r, err_nxt_s;
  logic              sram_en_r, sram_en_nxt_s;
  logic              sram_we_r, sram_we_nxt_s;
  logic [3:0]        sram_be_r, sram_be_nxt_s;
  logic [ADDR_W-1:0] sram_addr_r, sram_addr_nxt_s;
  logic [XLEN-1:0]   sram_wdata_r, sram_wdata_nxt_s;

  logic              req_s, illegal_s, misalign_s;
  logic [1:0]        align_lo_s, align_size_s;
  logic [3:0]        be_s;
  logic [XLEN-1:0]   wdata_rep_s, rdata_al_s;
  logic              unused_addr_s;

  // Upper address bits wrap within the SRAM.
  assign unused_addr_s = &{1'b0, mem_addr[XLEN-1:ADDR_W+2]};

  assign req_s     = mem_read_en | mem_write_en;
  assign illegal_s = misalign_s | (mem_read_en & mem_write_en);

  // While idle the aligner checks the live request; afterwards it uses the latched one.
  assign align_lo_s   = (state_r == ST_IDLE) ? mem_addr[1:0] : addr_lo_r;
  assign align_size_s = (state_r == ST_IDLE) ? byte_size     : size_r;

  dmem_lane_align u_align (
    .addr_lo   (align_lo_s),
    .byte_size (align_size_s),
    .wdata     (mem_data),
    .rdata     (sram_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_al  (rdata_al_s),
    .misalign  (misalign_s)
  );

  // Next-state and next-output logic; pulses default low, data paths hold.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    addr_lo_nxt_s    = addr_lo_r;
    size_nxt_s       = size_r;
    rd_req_nxt_s     = rd_req_r;
    wr_req_nxt_s     = wr_req_r;
    err_pend_nxt_s   = err_pend_r;
    data_in_nxt_s    = data_in_r;
    rd_rdy_nxt_s     = 1'b0;
    wr_rdy_nxt_s     = 1'b0;
    err_nxt_s        = 1'b0;
    sram_en_nxt_s    = 1'b0;
    sram_we_nxt_s    = 1'b0;
    sram_be_nxt_s    = 4'b0000;
    sram_addr_nxt_s  = sram_addr_r;
    sram_wdata_nxt_s = sram_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          addr_lo_nxt_s = mem_addr[1:0];
          size_nxt_s    = byte_size;
          rd_req_nxt_s  = mem_read_en;
          wr_req_nxt_s  = mem_write_en;
          if (illegal_s) begin
            // Rejected requests skip the SRAM and answer one edge later.
            err_pend_nxt_s = 1'b1;
            cnt_nxt_s      = 4'd0;
            state_nxt_s    = ST_WAIT;
          end else begin
            err_pend_nxt_s   = 1'b0;
            sram_en_nxt_s    = 1'b1;
            sram_we_nxt_s    = mem_write_en;
            sram_be_nxt_s    = mem_write_en ? be_s : 4'b0000;
            sram_addr_nxt_s  = mem_addr[ADDR_W+1:2];
            sram_wdata_nxt_s = mem_write_en ? wdata_rep_s : {XLEN{1'b0}};
            state_nxt_s      = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt_s   = 4'(WAIT_CYCLES);
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          rd_rdy_nxt_s = rd_req_r;
          wr_rdy_nxt_s = wr_req_r;
          err_nxt_s    = err_pend_r;
          if (err_pend_r) begin
            data_in_nxt_s = {XLEN{1'b0}};
          end else if (rd_req_r) begin
            data_in_nxt_s = rdata_al_s;
          end else begin
            data_in_nxt_s = data_in_r;
          end
          state_nxt_s = ST_RELEASE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RELEASE: begin
        if (!mem_read_en && !mem_write_en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      addr_lo_r    <= 2'b00;
      size_r       <= 2'b00;
      rd_req_r     <= 1'b0;
      wr_req_r     <= 1'b0;
      err_pend_r   <= 1'b0;
      data_in_r    <= {XLEN{1'b0}};
      rd_rdy_r     <= 1'b0;
      wr_rdy_r     <= 1'b0;
      err_r        <= 1'b0;
      sram_en_r    <= 1'b0;
      sram_we_r    <= 1'b0;
      sram_be_r    <= 4'b0000;
      sram_addr_r  <= {ADDR_W{1'b0}};
      sram_wdata_r <= {XLEN{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      addr_lo_r    <= addr_lo_nxt_s;
      size_r       <= size_nxt_s;
      rd_req_r     <= rd_req_nxt_s;
      wr_req_r     <= wr_req_nxt_s;
      err_pend_r   <= err_pend_nxt_s;
      data_in_r    <= data_in_nxt_s;
      rd_rdy_r     <= rd_rdy_nxt_s;
      wr_rdy_r     <= wr_rdy_nxt_s;
      err_r        <= err_nxt_s;
      sram_en_r    <= sram_en_nxt_s;
      sram_we_r    <= sram_we_nxt_s;
      sram_be_r    <= sram_be_nxt_s;
      sram_addr_r  <= sram_addr_nxt_s;
      sram_wdata_r <= sram_wdata_nxt_s;
    end
  end

  assign mem_data_in     = data_in_r;
  assign mem_read_ready  = rd_rdy_r;
  assign mem_write_ready = wr_rdy_r;
  assign mem_err         = err_r;
  assign sram_en         = sram_en_r;
  assign sram_we         = sram_we_r;
  assign sram_be         = sram_be_r;
  assign sram_addr       = sram_addr_r;
  assign sram_wdata      = sram_wdata_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (0 and 3 wait states) each with a
// behavioural byte-enabled SRAM, driven by directed load/store steps.
module tb_dmem_ctrl;

  localparam int AW = 6;

  typedef struct {
    logic        rd_rdy;
    logic        wr_rdy;
    logic        err;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0]   mem_addr        [2];
  logic [31:0]   mem_data        [2];
  logic [1:0]    byte_size       [2];
  logic          mem_read_en     [2];
  logic          mem_write_en    [2];
  logic [31:0]   mem_data_in     [2];
  logic          mem_read_ready  [2];
  logic          mem_write_ready [2];
  logic          mem_err         [2];
  logic          sram_en         [2];
  logic          sram_we         [2];
  logic [3:0]    sram_be         [2];
  logic [AW-1:0] sram_addr       [2];
  logic [31:0]   sram_wdata      [2];
  logic [31:0]   sram_rdata      [2];
  logic [31:0]   sram_mem        [2][64];

  int   wc [2] = '{0, 3};
  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.XLEN(32), .ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .byte_size(byte_size[0]),
    .mem_read_en(mem_read_en[0]), .mem_write_en(mem_write_en[0]),
    .mem_data_in(mem_data_in[0]), .mem_read_ready(mem_read_ready[0]),
    .mem_write_ready(mem_write_ready[0]), .mem_err(mem_err[0]),
    .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_be(sram_be[0]),
    .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0])
  );

  dmem_ctrl #(.XLEN(32), .ADDR_W(AW), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .byte_size(byte_size[1]),
    .mem_read_en(mem_read_en[1]), .mem_write_en(mem_write_en[1]),
    .mem_data_in(mem_data_in[1]), .mem_read_ready(mem_read_ready[1]),
    .mem_write_ready(mem_write_ready[1]), .mem_err(mem_err[1]),
    .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_be(sram_be[1]),
    .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1])
  );

  // Synchronous SRAM models; read data appears the cycle after the strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sram_en[d]) begin
        if (sram_we[d]) begin
          for (int b = 0; b < 4; b++) begin
            if (sram_be[d][b]) sram_mem[d][sram_addr[d]][8*b +: 8] <= sram_wdata[d][8*b +: 8];
          end
        end else begin
          sram_rdata[d] <= sram_mem[d][sram_addr[d]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_req(input string tag, input int d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                        input logic exp_err, input logic [3:0] exp_be, input logic [AW-1:0] exp_saddr,
                        input logic [31:0] exp_swdata, input logic [31:0] exp_rdata, input int hold);
    int e, rdy_e, en_cnt, extra;
    logic [3:0] be_c;
    logic [AW-1:0] a_c;
    logic [31:0] wd_c;
    logic we_c;
    exp_t ex, got;
    @(negedge clk);
    mem_addr[d] = addr; mem_data[d] = wdata; byte_size[d] = size;
    mem_read_en[d] = rd; mem_write_en[d] = wr;
    ex.rd_rdy = rd; ex.wr_rdy = wr; ex.err = exp_err;
    ex.data = exp_err ? 32'd0 : exp_rdata; ex.chk_data = rd | exp_err;
    sb_q.push_back(ex);
    got = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    e = 0; rdy_e = -1; en_cnt = 0; extra = 0;
    be_c = 4'd0; a_c = '0; wd_c = 32'd0; we_c = 1'b0;
    while (rdy_e < 0 && e < 40) begin
      @(posedge clk); #1;
      if (sram_en[d]) begin
        en_cnt++; be_c = sram_be[d]; a_c = sram_addr[d]; wd_c = sram_wdata[d]; we_c = sram_we[d];
      end
      if (mem_read_ready[d] || mem_write_ready[d] || mem_err[d]) begin
        rdy_e = e;
        got.rd_rdy = mem_read_ready[d]; got.wr_rdy = mem_write_ready[d];
        got.err = mem_err[d]; got.data = mem_data_in[d];
      end
      e++;
    end
    check({tag, " latency"}, 32'(rdy_e), exp_err ? 32'd1 : 32'(2 + wc[d]));
    ex = sb_q.pop_front();
    check({tag, " read_ready"}, {31'd0, got.rd_rdy}, {31'd0, ex.rd_rdy});
    check({tag, " write_ready"}, {31'd0, got.wr_rdy}, {31'd0, ex.wr_rdy});
    check({tag, " err"}, {31'd0, got.err}, {31'd0, ex.err});
    if (ex.chk_data) check({tag, " data"}, got.data, ex.data);
    if (!exp_err) begin
      check({tag, " sram_be"}, {28'd0, be_c}, {28'd0, exp_be});
      check({tag, " sram_addr"}, 32'(a_c), 32'(exp_saddr));
      check({tag, " sram_we"}, {31'd0, we_c}, {31'd0, wr});
      if (wr) check({tag, " sram_wdata"}, wd_c, exp_swdata);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (sram_en[d]) en_cnt++;
      if (mem_read_ready[d] || mem_write_ready[d] || mem_err[d]) extra++;
    end
    mem_read_en[d] = 1'b0; mem_write_en[d] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (sram_en[d]) en_cnt++;
      if (mem_read_ready[d] || mem_write_ready[d] || mem_err[d]) extra++;
    end
    check({tag, " sram_en count"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
    check({tag, " extra pulses"}, 32'(extra), 32'd0);
    if (ex.chk_data) check({tag, " data held"}, mem_data_in[d], ex.data);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mem_addr[d] = 32'd0; mem_data[d] = 32'd0; byte_size[d] = 2'd0;
      mem_read_en[d] = 1'b0; mem_write_en[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset data_in", mem_data_in[d], 32'd0);
      check("reset ctl", {23'd0, mem_read_ready[d], mem_write_ready[d], mem_err[d],
                          sram_en[d], sram_we[d], sram_be[d]}, 32'd0);
      check("reset sram_addr/wdata", sram_wdata[d] | 32'(sram_addr[d]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // zero wait states
    do_req("sw 0x10", 0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 4'b1111, 6'd4, 32'hDEADBEEF, 32'd0, 0);
    do_req("lw 0x10", 0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, 1'b0, 4'b0000, 6'd4, 32'd0, 32'hDEADBEEF, 0);
    do_req("sb 0x13", 0, 1'b0, 1'b1, 32'h13, 32'h000000A5, 2'd1, 1'b0, 4'b1000, 6'd4, 32'hA5A5A5A5, 32'd0, 0);
    do_req("lbu 0x13", 0, 1'b1, 1'b0, 32'h13, 32'd0, 2'd1, 1'b0, 4'b0000, 6'd4, 32'd0, 32'h000000A5, 0);
    do_req("lw after sb", 0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, 1'b0, 4'b0000, 6'd4, 32'd0, 32'hA5ADBEEF, 0);
    do_req("sh 0x16", 0, 1'b0, 1'b1, 32'h16, 32'h00001234, 2'd2, 1'b0, 4'b1100, 6'd5, 32'h12341234, 32'd0, 0);
    do_req("lhu 0x16", 0, 1'b1, 1'b0, 32'h16, 32'd0, 2'd2, 1'b0, 4'b0000, 6'd5, 32'd0, 32'h00001234, 0);
    do_req("lhu 0x15 misaligned", 0, 1'b1, 1'b0, 32'h15, 32'd0, 2'd2, 1'b1, 4'b0000, 6'd0, 32'd0, 32'd0, 0);
    do_req("both enables", 0, 1'b1, 1'b1, 32'h20, 32'h11111111, 2'd0, 1'b1, 4'b0000, 6'd0, 32'd0, 32'd0, 0);
    do_req("size 3 store", 0, 1'b0, 1'b1, 32'h20, 32'h22222222, 2'd3, 1'b1, 4'b0000, 6'd0, 32'd0, 32'd0, 0);
    do_req("lw 0x110 wrap", 0, 1'b1, 1'b0, 32'h110, 32'd0, 2'd0, 1'b0, 4'b0000, 6'd4, 32'd0, 32'hA5ADBEEF, 0);
    do_req("lw 0x12 misaligned", 0, 1'b1, 1'b0, 32'h12, 32'd0, 2'd0, 1'b1, 4'b0000, 6'd0, 32'd0, 32'd0, 0);

    // three wait states, including an enable held well past ready
    do_req("w3 sw 0x8", 1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 2'd0, 1'b0, 4'b1111, 6'd2, 32'hCAFEF00D, 32'd0, 0);
    do_req("w3 lw 0x8 held", 1, 1'b1, 1'b0, 32'h8, 32'd0, 2'd0, 1'b0, 4'b0000, 6'd2, 32'd0, 32'hCAFEF00D, 4);
    do_req("w3 lbu 0x9", 1, 1'b1, 1'b0, 32'h9, 32'd0, 2'd1, 1'b0, 4'b0000, 6'd2, 32'd0, 32'h000000F0, 0);

    // reset while waiting on the SRAM
    begin
      int extra_rdy;
      extra_rdy = 0;
      @(negedge clk);
      mem_addr[1] = 32'h8; byte_size[1] = 2'd0; mem_read_en[1] = 1'b1;
      repeat (3) @(posedge clk);
      #2; rst = 1'b1; #1;
      check("async reset data_in", mem_data_in[1], 32'd0);
      check("async reset ctl", {23'd0, mem_read_ready[1], mem_write_ready[1], mem_err[1],
                                sram_en[1], sram_we[1], sram_be[1]}, 32'd0);
      @(negedge clk); mem_read_en[1] = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (8) begin
        @(posedge clk); #1;
        if (mem_read_ready[1] || mem_write_ready[1] || mem_err[1] || sram_en[1]) extra_rdy++;
      end
      check("no response after reset", 32'(extra_rdy), 32'd0);
    end
    do_req("w3 lw after reset", 1, 1'b1, 1'b0, 32'h8, 32'd0, 2'd0, 1'b0, 4'b0000, 6'd2, 32'd0, 32'hCAFEF00D, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
